// File: rtl/vreg_drain_pkg.sv
// Shared vector geometry and drain FSM encoding for vreg_drain.
// VW is LENGTH*INT8; BUS_W must divide VW evenly.
package vreg_drain_pkg;

    localparam int LENGTH = 16;
    localparam int INT8   = 8;
    localparam int VW     = LENGTH * INT8;
    localparam int BUS_W  = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/vreg_beat_serializer.sv
// VW-bit shift buffer emitting BUS_W-bit beats, least-significant lane first.
// Load has priority over shift; last_beat flags the final beat of the loaded word.
module vreg_beat_serializer #(
    parameter int VW    = 128,
    parameter int BUS_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [VW-1:0]    load_data,
    input  logic             shift,
    output logic [BUS_W-1:0] beat,
    output logic             last_beat
);

    localparam int BEATS = VW / BUS_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    logic [VW-1:0] buffer;
    logic [CW-1:0] beat_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buffer   <= '0;
            beat_cnt <= '0;
        end else if (load) begin
            buffer   <= load_data;
            beat_cnt <= '0;
        end else if (shift) begin
            buffer   <= buffer >> BUS_W;
            beat_cnt <= beat_cnt + CW'(1);
        end
    end

    assign beat      = buffer[BUS_W-1:0];
    assign last_beat = (beat_cnt == LAST_CNT);

endmodule

// File: rtl/vreg_drain.sv
// Drains a contiguous run of vector registers to memory as BUS_W-bit valid/ready beats.
// One FETCH bubble per register; beat outputs hold while mem_valid && !mem_ready.
module vreg_drain #(
    parameter int LENGTH = vreg_drain_pkg::LENGTH,
    parameter int INT8   = vreg_drain_pkg::INT8,
    parameter int BUS_W  = vreg_drain_pkg::BUS_W,
    parameter int ADDR_W = vreg_drain_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [4:0]               base_reg,
    input  logic [5:0]               reg_count,
    input  logic [ADDR_W-1:0]        mem_base,
    output logic [4:0]               rf_addr,
    input  logic [LENGTH*INT8-1:0]   rf_data,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [BUS_W-1:0]         mem_wdata,
    output logic                     mem_last,
    output logic                     busy,
    output logic                     done
);
    import vreg_drain_pkg::*;

    localparam int VWL   = LENGTH * INT8;
    localparam int BYTES = BUS_W / 8;

    state_t            state, state_nxt;
    logic [4:0]        reg_idx;
    logic [5:0]        remaining;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q;
    logic              last_beat;
    logic              handshake;
    logic              final_reg;

    assign handshake = (state == SEND) && mem_ready;
    assign final_reg = (remaining == 6'd1);

    vreg_beat_serializer #(
        .VW    (VWL),
        .BUS_W (BUS_W)
    ) u_ser (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (state == FETCH),
        .load_data (rf_data),
        .shift     (handshake),
        .beat      (mem_wdata),
        .last_beat (last_beat)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (reg_count == 6'd0) ? DONE : FETCH;
            end
            FETCH: state_nxt = SEND;
            SEND: begin
                if (handshake && last_beat) state_nxt = final_reg ? DONE : FETCH;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // reg_idx only moves on edges that enter FETCH, so rf_addr holds elsewhere.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            reg_idx   <= '0;
            remaining <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start && reg_count != 6'd0) begin
                        reg_idx   <= base_reg;
                        remaining <= reg_count;
                        addr_q    <= mem_base;
                        busy_q    <= 1'b1;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        addr_q <= addr_q + ADDR_W'(BYTES);
                        if (last_beat && !final_reg) begin
                            reg_idx   <= reg_idx + 5'd1;
                            remaining <= remaining - 6'd1;
                        end
                    end
                end
                DONE:    busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign rf_addr   = reg_idx;
    assign mem_valid = (state == SEND);
    assign mem_addr  = addr_q;
    assign mem_last  = (state == SEND) && final_reg && last_beat;
    assign busy      = busy_q;
    assign done      = (state == DONE);

endmodule
